// File: rtl/idss_ctrl_pkg.sv
// Shared constants, state type and output decode for the IDSS column-load sequencer.
package idss_ctrl_pkg;

    localparam int unsigned NB_CSS          = 4;
    localparam int unsigned COLS_PER_WINDOW = 3;
    localparam int unsigned SLOT_W          = $clog2(NB_CSS);
    localparam int unsigned STEP_W          = $clog2(COLS_PER_WINDOW + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StWin,
        StDone
    } idss_ctrl_state_t;

    typedef struct packed {
        logic in_ready;
        logic shift;
        logic win_valid;
        logic busy;
        logic done;
    } idss_ctrl_out_t;

    // Output pattern presented while the FSM sits in a given state.
    function automatic idss_ctrl_out_t state_outs(idss_ctrl_state_t st);
        idss_ctrl_out_t o;
        o = '0;
        case (st)
            StLoad: begin
                o.in_ready = 1'b1;
                o.busy     = 1'b1;
            end
            StShift: begin
                o.shift = 1'b1;
                o.busy  = 1'b1;
            end
            StWin: begin
                o.win_valid = 1'b1;
                o.busy      = 1'b1;
            end
            StDone: begin
                o.done = 1'b1;
                o.busy = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/idss_ctrl_wrap_cnt.sv
// Up-counter that wraps to zero after reaching a runtime maximum; flags the last value.
module wrap_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] count_q;

    assign count = count_q;
    assign last  = (count_q == max_val);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= last ? '0 : count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/idss_ctrl.sv
// Sequencer that steers column beats into CSS slots, strobes the global shift and
// hands complete windows to the PE array.
module idss_ctrl
    import idss_ctrl_pkg::*;
#(
    parameter int unsigned WIN_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     start,
    input  logic [WIN_CNT_WIDTH-1:0] nb_windows,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SLOT_W-1:0]        LE_select,
    output logic                     le_en,
    output logic                     shift,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     busy,
    output logic                     done
);

    idss_ctrl_state_t         state_q, state_d;
    idss_ctrl_out_t           out_q;
    logic [STEP_W-1:0]        step_cnt;
    logic                     primed;
    logic [WIN_CNT_WIDTH-1:0] nb_last_q;
    logic [WIN_CNT_WIDTH-1:0] win_cnt;
    logic [SLOT_W-1:0]        slot_cnt;
    logic                     slot_last;
    logic                     win_last;
    logic                     beat;
    logic                     win_xfer;
    logic                     step_final;
    logic                     unused_win_cnt;

    // in_ready is a registered copy of "state is LOAD", so no in_valid -> in_ready path.
    assign beat       = out_q.in_ready & in_valid;
    assign win_xfer   = out_q.win_valid & win_ready;
    assign step_final = primed || (step_cnt == STEP_W'(COLS_PER_WINDOW - 1));

    wrap_cnt #(
        .WIDTH (SLOT_W)
    ) u_slot_cnt (
        .clk     (clk),
        .rst_n   (arst_n_in),
        .clear   (state_q == StIdle),
        .inc     (beat),
        .max_val (SLOT_W'(NB_CSS - 1)),
        .count   (slot_cnt),
        .last    (slot_last)
    );

    wrap_cnt #(
        .WIDTH (WIN_CNT_WIDTH)
    ) u_win_cnt (
        .clk     (clk),
        .rst_n   (arst_n_in),
        .clear   (state_q == StIdle),
        .inc     (win_xfer),
        .max_val (nb_last_q),
        .count   (win_cnt),
        .last    (win_last)
    );

    assign unused_win_cnt = ^win_cnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (nb_windows != '0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                if (in_valid && slot_last) begin
                    state_d = StShift;
                end
            end
            StShift: state_d = step_final ? StWin : StLoad;
            StWin: begin
                if (win_ready) begin
                    state_d = win_last ? StDone : StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q   <= StIdle;
            out_q     <= '0;
            step_cnt  <= '0;
            primed    <= 1'b0;
            nb_last_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= state_outs(state_d);
            if (state_q == StIdle && start && nb_windows != '0) begin
                nb_last_q <= nb_windows - WIN_CNT_WIDTH'(1);
                step_cnt  <= '0;
                primed    <= 1'b0;
            end
            if (state_q == StShift) begin
                if (step_final) begin
                    primed <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + STEP_W'(1);
                end
            end
        end
    end

    assign in_ready  = out_q.in_ready;
    assign shift     = out_q.shift;
    assign win_valid = out_q.win_valid;
    assign busy      = out_q.busy;
    assign done      = out_q.done;
    assign LE_select = slot_cnt;
    assign le_en     = beat;

endmodule

// File: tb/tb_idss_ctrl.sv
// Self-checking bench for idss_ctrl: table of run scenarios plus reset sequences,
// with queued expected beat slots and window hand-off cycles.
module tb_idss_ctrl;
    import idss_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic [15:0] nb_windows;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  LE_select;
    logic        le_en;
    logic        shift;
    logic        win_valid;
    logic        win_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    idss_ctrl #(
        .WIN_CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .start      (start),
        .nb_windows (nb_windows),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .LE_select  (LE_select),
        .le_en      (le_en),
        .shift      (shift),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        string name;
        int    nb;
        bit    bubble;
        int    wr_hold;
        int    restart_at;
        int    exp_first_win;
        int    exp_done;
        int    exp_beats;
        int    exp_shifts;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_slot_q[$];
    int exp_win_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_le_en"}, le_en, 0);
        check({tag, "_shift"}, shift, 0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_le_select"}, LE_select, 0);
    endtask

    task automatic run_case(input vec_t v);
        int   done_cyc, first_win, beats, shifts, hold_left, stepcyc, t, acc, nbeats;
        bit   phase, prev_wv, prev_wr;
        logic [1:0] prev_sel;
        // Expected hand-off cycles: priming takes COLS steps, each later window one step.
        stepcyc = (v.bubble ? 2 * NB_CSS : NB_CSS) + 1;
        nbeats  = 0;
        if (v.nb != 0) begin
            t = 1 + COLS_PER_WINDOW * stepcyc;
            for (int k = 0; k < v.nb; k++) begin
                acc = t + ((k == 0) ? v.wr_hold : 0);
                exp_win_q.push_back(acc);
                t = acc + 1 + stepcyc;
            end
            nbeats = NB_CSS * (COLS_PER_WINDOW + v.nb - 1);
            for (int i = 0; i < nbeats; i++) exp_slot_q.push_back(i % NB_CSS);
        end
        done_cyc  = -1;
        first_win = -1;
        beats     = 0;
        shifts    = 0;
        phase     = 1'b0;
        hold_left = v.wr_hold;
        prev_wv   = 1'b0;
        prev_wr   = 1'b0;
        prev_sel  = '0;
        for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start      = (cyc == 0) || (cyc == v.restart_at);
            nb_windows = (cyc == 0) ? 16'(v.nb) : 16'hFFFF;
            in_valid   = v.bubble ? (in_ready & phase) : 1'b1;
            win_ready  = !(win_valid && hold_left > 0);
            #1;
            check({v.name, "_shift_le_excl"}, shift & le_en, 0);
            if (prev_wv && !prev_wr) begin
                check({v.name, "_win_hold"}, win_valid, 1);
                check({v.name, "_sel_stable"}, LE_select, prev_sel);
            end
            if (in_valid && in_ready) begin
                beats++;
                if (exp_slot_q.size() == 0) check({v.name, "_beat_unexpected"}, beats, nbeats);
                else check({v.name, "_le_select"}, LE_select, exp_slot_q.pop_front());
            end
            if (shift) shifts++;
            if (win_valid && first_win < 0) first_win = cyc;
            if (win_valid && win_ready) begin
                if (exp_win_q.size() == 0) check({v.name, "_win_unexpected"}, cyc, -1);
                else check({v.name, "_win_cycle"}, cyc, exp_win_q.pop_front());
            end
            if (done) done_cyc = cyc;
            if (in_ready) phase = ~phase;
            if (win_valid && hold_left > 0) hold_left--;
            prev_wv  = win_valid;
            prev_wr  = win_ready;
            prev_sel = LE_select;
        end
        start = 1'b0;
        check({v.name, "_done_cycle"}, done_cyc, v.exp_done);
        check({v.name, "_first_win"}, first_win, v.exp_first_win);
        check({v.name, "_beats"}, beats, v.exp_beats);
        check({v.name, "_shifts"}, shifts, v.exp_shifts);
        check({v.name, "_wins_left"}, exp_win_q.size(), 0);
        check({v.name, "_slots_left"}, exp_slot_q.size(), 0);
        exp_win_q.delete();
        exp_slot_q.delete();
        @(negedge clk);
        #1;
        check({v.name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        //         name       nb bub hold rst  first done beats shifts
        vecs[0] = '{"basic",   1, 0,  0, -1,  16,  17,  12,  3};
        vecs[1] = '{"steady",  5, 0,  0, -1,  16,  41,  28,  7};
        vecs[2] = '{"bubble",  1, 1,  0, -1,  28,  29,  12,  3};
        vecs[3] = '{"bubble2", 2, 1,  0, -1,  28,  39,  16,  4};
        vecs[4] = '{"wr_hold", 2, 0, 10, -1,  16,  33,  16,  4};
        vecs[5] = '{"zero",    0, 0,  0, -1,  -1,   1,   0,  0};
        vecs[6] = '{"restart", 3, 0,  0, 10,  16,  29,  20,  5};

        arst_n_in  = 1'b0;
        start      = 1'b1;
        nb_windows = 16'd1;
        in_valid   = 1'b1;
        win_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_quiet("reset");
        end
        @(negedge clk);
        arst_n_in = 1'b1;
        start     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_busy", busy, 0);
            check("post_reset_in_ready", in_ready, 0);
        end

        foreach (vecs[i]) run_case(vecs[i]);

        // Abort a run with reset during its second SHIFT cycle.
        begin
            int shifts_seen;
            shifts_seen = 0;
            for (int cyc = 0; cyc <= 10; cyc++) begin
                @(negedge clk);
                start      = (cyc == 0);
                nb_windows = 16'd1;
                in_valid   = 1'b1;
                win_ready  = 1'b1;
                #1;
                if (shift) shifts_seen++;
            end
            check("midrun_second_shift", shift, 1);
            check("midrun_shift_count", shifts_seen, 2);
            arst_n_in = 1'b0;
            @(negedge clk);
            #1;
            check_quiet("midrun_reset");
            arst_n_in = 1'b1;
            @(negedge clk);
            #1;
            check("midrun_idle", busy, 0);
        end
        run_case(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idss_ctrl.md
Name: idss_ctrl

Overview:
- Sequencer for the 4-slot input data shift structure (one CSS per slot, 3 row inputs, `LE_select` and `shift`).
- Accepts a stream of 3-pixel column beats from the input fetch path and steers each beat into the correct CSS slot.
- Issues the global shift strobe between column steps.
- Presents a "window valid" handshake to the downstream PE array once all 36 outputs hold a coherent window. Sits between the input fetch unit and the datapath top level.

Parameters:
- NB_CSS, 4, number of CSS slots addressed by `LE_select`.
- COLS_PER_WINDOW, 3, column steps needed to prime a full window after start.
- WIN_CNT_WIDTH, 16, width of the window-count input and internal window counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- arst_n_in  in  1  reset, synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- nb_windows  in  WIN_CNT_WIDTH  windows to produce this run; latched on accepted start.
- in_valid  in  1  column beat (`row_1..3`) present at datapath input.
- in_ready  out  1  controller accepts the beat this cycle.
- LE_select  out  2  CSS slot targeted by the current beat.
- le_en  out  1  qualifies `LE_select`; top level gates all CSS load enables with it.
- shift  out  1  one-cycle global shift strobe to all CSS.
- win_valid  out  1  the 36 IDSS outputs form a valid window.
- win_ready  in  1  downstream consumed the window.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (`arst_n_in`=0 at a clock edge):
  - state=IDLE, all counters 0.
  - Outputs `in_ready`, `le_en`, `shift`, `win_valid`, `busy`, `done`, `LE_select` are all 0.
  - Reset mid-run abandons the run: no `done`, and IDSS contents are don't-care.
- States:
  - IDLE:
    - `start`=1 with `nb_windows`≠0: latch `nb_windows`; `slot_cnt`=0, `step_cnt`=0, `win_cnt`=0, `primed`=0; go to LOAD.
    - `start`=1 with `nb_windows`=0: go to DONE.
  - LOAD:
    - `in_ready`=1, `LE_select`=`slot_cnt`, `le_en`=`in_valid`.
    - On `in_valid`: if `slot_cnt`=NB_CSS-1, `slot_cnt`←0 and go to SHIFT; otherwise `slot_cnt`++.
    - No `in_valid`: hold all state (bubbles allowed; no timeout).
  - SHIFT:
    - One cycle; `shift`=1, `in_ready`=0, `le_en`=0.
    - If `primed`, or `step_cnt`=COLS_PER_WINDOW-1: set `primed`=1 and go to WIN.
    - Otherwise `step_cnt`++ and go to LOAD.
  - WIN:
    - `win_valid`=1, held until `win_ready`; `in_ready`=0.
    - On `win_ready`: if `win_cnt`=latched `nb_windows`-1, go to DONE; otherwise `win_cnt`++ and go to LOAD (single column step).
  - DONE: `done`=1 for one cycle, `busy`=1; go to IDLE.
- Handshakes:
  - A beat transfers iff `in_valid` & `in_ready`.
  - A window transfers iff `win_valid` & `win_ready`.
  - `win_valid` never drops without `win_ready`.
  - `LE_select` is stable while `win_valid` is high.
- `start` outside IDLE is ignored, as is a change of `nb_windows` mid-run.
- `shift` and `le_en` are never high in the same cycle.
- Outputs are registered or decoded from state only; no combinational path from `in_valid` to `in_ready`.
- Latency, with `in_valid` held 1 and start sampled at cycle 0:
  - First `win_valid` at cycle 1+COLS_PER_WINDOW·(NB_CSS+1) = 16.
  - Subsequent windows are every NB_CSS+2 = 6 cycles when `win_ready` is tied 1.
- Counters:
  - `slot_cnt` is log2(NB_CSS) bits and wraps NB_CSS-1→0.
  - `step_cnt` saturates once priming is done.
  - `win_cnt` is compared with equality, no overflow; `nb_windows`=2^WIN_CNT_WIDTH-1 is legal.

Decomposition:
- Package `idss_ctrl_pkg`:
  - State enum `idss_ctrl_state_t` (IDLE, LOAD, SHIFT, WIN, DONE).
  - Constants NB_CSS and COLS_PER_WINDOW.
  - Localparam SLOT_W = $clog2(NB_CSS).
- One sub-module, `wrap_cnt`: parameterised width/max, with `clear`, `inc`, and a `last` flag. Instanced for `slot_cnt` and `win_cnt`.
- FSM and output decode stay in `idss_ctrl`.

Test Plan:
- Reset:
  - Drive `arst_n_in`=0 for 2 cycles with `start`=1 → all outputs 0, `busy`=0.
  - Release → still IDLE until `start` is sampled.
- Basic run:
  - `nb_windows`=1, `in_valid`=1, `win_ready`=1.
  - Expected: `LE_select` sequence 0,1,2,3 then `shift`, repeated 3×.
  - Expected: `win_valid` at cycle 16 for 1 cycle, `done` at cycle 17, 12 beats accepted total.
- Steady state:
  - `nb_windows`=5, `win_ready`=1.
  - Expected: `win_valid` at cycles 16, 22, 28, 34, 40; 12+4·4=28 beats accepted; `done` at 41.
- Backpressure and bubbles:
  - Deassert `in_valid` every other cycle → `LE_select` holds, `slot_cnt` does not advance, first `win_valid` at cycle 28.
  - Hold `win_ready`=0 for 10 cycles → `win_valid` stays 1 with no beats accepted.
- Edge inputs:
  - `nb_windows`=0 → `done` one cycle after start, zero beats accepted.
  - `start` pulsed while busy → ignored, window count unchanged.
- Reset mid-run:
  - Assert reset during the second SHIFT → next cycle IDLE with all outputs 0.
  - New start with `nb_windows`=1 → behaves exactly as the basic run.
